// File: rtl/exa_crosb_pkg.sv
// Shared types and helpers for the crossbar route controller.
package exa_crosb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DROP = 2'd3
  } route_state_t;

  // Widest flit the destination extractor accepts; narrower flits are zero-extended.
  localparam int unsigned FLIT_MAX_W = 1024;

  function automatic logic [31:0] get_dst(input logic [FLIT_MAX_W-1:0] flit,
                                          input int unsigned           lsb,
                                          input int unsigned           width);
    logic [FLIT_MAX_W-1:0] shifted;
    logic [31:0]           mask;
    shifted = flit >> lsb;
    mask    = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/exa_crosb_route_ctrl.sv
// Per-input route controller: peeks header destination, locks the output arbiter, streams the packet.
// Optional packet counter output enabled by defining EXA_CROSB_ROUTE_PKT_CNT_EN.
module exa_crosb_route_ctrl
  import exa_crosb_pkg::*;
#(
  parameter int unsigned data_width    = 128,
  parameter int unsigned output_num    = 16,
  parameter int unsigned sel_width     = $clog2(output_num),
  parameter int unsigned dst_lsb       = 0,
  parameter int unsigned dst_width     = sel_width,
  parameter int unsigned max_pkt_flits = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [data_width-1:0] IN_DATA_i,
  input  logic                  IN_VALID_i,
  input  logic                  IN_LAST_i,
  output logic                  IN_READY_o,
  output logic [output_num-1:0] REQ_o,
  input  logic [output_num-1:0] GNT_i,
  input  logic                  READY_i,
  output logic [data_width-1:0] DATA_o,
  output logic                  VALID_o,
  output logic                  LAST_o,
  output logic [sel_width-1:0]  SEL_o,
  output logic                  ERR_DST_o,
`ifdef EXA_CROSB_ROUTE_PKT_CNT_EN
  output logic                  ERR_LEN_o,
  output logic [31:0]           PKT_CNT_o
`else
  output logic                  ERR_LEN_o
`endif
);

  localparam int unsigned CNT_W = $clog2(max_pkt_flits + 1);

  route_state_t          state_q, state_d;
  logic [sel_width-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_dst_q, err_dst_d;
  logic                  err_len_q, err_len_d;

  logic [FLIT_MAX_W-1:0] flit_ext_s;
  logic [31:0]           dst_s;
  logic                  dst_ok_s;
  logic [output_num-1:0] sel_onehot_s;
  logic                  gnt_s;

  assign flit_ext_s   = FLIT_MAX_W'(IN_DATA_i);
  assign dst_s        = get_dst(flit_ext_s, dst_lsb, dst_width);
  assign dst_ok_s     = (dst_s < 32'(output_num));
  assign sel_onehot_s = output_num'(1'b1) << sel_q;
  // Only the grant line of the locked output matters; others belong to other inputs.
  assign gnt_s        = |(GNT_i & sel_onehot_s);

  // Next-state and combinational pass-through toward the demux.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    err_dst_d  = err_dst_q;
    err_len_d  = err_len_q;
    REQ_o      = '0;
    IN_READY_o = 1'b0;
    VALID_o    = 1'b0;
    DATA_o     = '0;
    LAST_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (IN_VALID_i) begin
          if (dst_ok_s) begin
            sel_d   = dst_s[sel_width-1:0];
            state_d = REQ;
          end else begin
            err_dst_d = 1'b1;
            state_d   = DROP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        REQ_o = sel_onehot_s;
        if (gnt_s) begin
          state_d = XFER;
        end else begin
          state_d = REQ;
        end
      end
      XFER: begin
        REQ_o      = sel_onehot_s;
        VALID_o    = gnt_s & IN_VALID_i;
        IN_READY_o = gnt_s & READY_i;
        if (VALID_o) begin
          DATA_o = IN_DATA_i;
          LAST_o = IN_LAST_i;
        end else begin
          DATA_o = '0;
          LAST_o = 1'b0;
        end
        if (VALID_o && READY_i) begin
          // Counter saturates so the length flag cannot re-trigger by wrapping.
          if (cnt_q != CNT_W'(max_pkt_flits)) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
          if (cnt_q == CNT_W'(max_pkt_flits - 1)) begin
            err_len_d = 1'b1;
          end else begin
            err_len_d = err_len_q;
          end
          if (IN_LAST_i) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            state_d = XFER;
          end
        end else begin
          state_d = XFER;
        end
      end
      DROP: begin
        IN_READY_o = 1'b1;
        if (IN_VALID_i && IN_LAST_i) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, route select, flit counter and sticky error registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      err_dst_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      err_dst_q <= err_dst_d;
      err_len_q <= err_len_d;
    end
  end

  assign SEL_o     = sel_q;
  assign ERR_DST_o = err_dst_q;
  assign ERR_LEN_o = err_len_q;

`ifdef EXA_CROSB_ROUTE_PKT_CNT_EN
  logic        pkt_done_s;
  logic [31:0] pkt_cnt_q;

  // Dropped packets never reach XFER, so they are never counted.
  assign pkt_done_s = (state_q == XFER) & gnt_s & IN_VALID_i & READY_i & IN_LAST_i;

  // Wrapping count of packets forwarded to the crossbar.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      pkt_cnt_q <= 32'd0;
    end else if (pkt_done_s) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end else begin
      pkt_cnt_q <= pkt_cnt_q;
    end
  end

  assign PKT_CNT_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_exa_crosb_route_ctrl.sv
// Directed scoreboard bench for exa_crosb_route_ctrl (12 outputs, 4-flit length limit).
module tb_exa_crosb_route_ctrl;

  localparam int DW   = 32;
  localparam int ON   = 12;
  localparam int SW   = 4;
  localparam int MAXF = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [ON-1:0] req;
  logic [ON-1:0] gnt = '0;
  logic          ready = 1'b1;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          last_o;
  logic [SW-1:0] sel_o;
  logic          err_dst;
  logic          err_len;
`ifdef EXA_CROSB_ROUTE_PKT_CNT_EN
  logic [31:0]   pkt_cnt;
`endif

  exa_crosb_route_ctrl #(
    .data_width(DW), .output_num(ON), .sel_width(SW),
    .dst_lsb(0), .dst_width(SW), .max_pkt_flits(MAXF)
  ) dut (
    .ACLK(clk), .ARESETN(rstn),
    .IN_DATA_i(in_data), .IN_VALID_i(in_valid), .IN_LAST_i(in_last), .IN_READY_o(in_ready),
    .REQ_o(req), .GNT_i(gnt), .READY_i(ready),
    .DATA_o(data_o), .VALID_o(valid_o), .LAST_o(last_o), .SEL_o(sel_o),
    .ERR_DST_o(err_dst),
`ifdef EXA_CROSB_ROUTE_PKT_CNT_EN
    .ERR_LEN_o(err_len),
    .PKT_CNT_o(pkt_cnt)
`else
    .ERR_LEN_o(err_len)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          xfers = 0;
  int          exp_sel = 0;
  bit          exp_err_len = 1'b0;
  bit          ready_toggle = 1'b0;
  logic [ON-1:0] req_seen = '0;
  logic [DW:0] sb_q[$];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arbiter model: grants one cycle after it sees the request, holds while requested.
  always @(negedge clk) req_seen = req;
  always @(posedge clk) begin
    #1;
    gnt   = req_seen;
    ready = ready_toggle ? ~ready : 1'b1;
  end

  // Demux-side monitor: pops the scoreboard on every transferred flit.
  always @(negedge clk) begin
    logic [DW:0] exp;
    if (rstn) begin
      if (valid_o && ready) begin
        xfers++;
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          exp = sb_q.pop_front();
          check("flit", 64'({last_o, data_o}), 64'(exp));
          check("sel_stable", 64'(sel_o), 64'(exp_sel));
          check("req_hold", 64'(req), 64'(ON'(1) << exp_sel));
        end
      end else if (!valid_o) begin
        check("gated_data", 64'({last_o, data_o}), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic drive_flit(input logic [DW-1:0] d, input bit last, input bit fwd, output bit acc);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (fwd) sb_q.push_back({last, d});
    acc = 1'b0;
    for (int c = 0; c < 64 && !acc; c++) begin
      @(negedge clk);
      if (!fwd) begin
        check("drop_req", 64'(req), 64'd0);
        check("drop_valid", 64'(valid_o), 64'd0);
      end
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic send_pkt(input logic [3:0] dst, input int n, input bit fwd, input logic [7:0] id);
    bit acc;
    if (fwd) exp_sel = int'(dst);
    for (int i = 0; i < n; i++) begin
      drive_flit({id, 8'(i), 12'h5A5, dst}, (i == n - 1), fwd, acc);
      if (acc && fwd) begin
        if (i + 1 == MAXF) exp_err_len = 1'b1;
        check("err_len_flit", 64'(err_len), 64'(exp_err_len));
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    int x0;
    bit acc;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_req", 64'(req), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_sel", 64'(sel_o), 64'd0);
    check("rst_err_dst", 64'(err_dst), 64'd0);
    check("rst_err_len", 64'(err_len), 64'd0);
    @(posedge clk); #1;

    // T1: 3-flit packet to output 5; header peeked, request one cycle later.
    in_valid = 1'b1;
    in_data  = {8'h01, 8'h00, 12'h5A5, 4'd5};
    @(negedge clk);
    check("t1_peek_ready", 64'(in_ready), 64'd0);
    check("t1_req_idle", 64'(req), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_req", 64'(req), 64'h020);
    check("t1_sel", 64'(sel_o), 64'd5);
    check("t1_valid_req", 64'(valid_o), 64'd0);
    check("t1_ready_req", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    x0 = xfers;
    send_pkt(4'd5, 3, 1'b1, 8'h01);
    @(negedge clk);
    check("t1_req_drop", 64'(req), 64'd0);
    check("t1_xfers", 64'(xfers - x0), 64'd3);
    @(posedge clk); #1;

    // T5: 6-flit packet over a 4-flit limit, all forwarded.
    x0 = xfers;
    send_pkt(4'd3, 6, 1'b1, 8'h05);
    check("t5_xfers", 64'(xfers - x0), 64'd6);
    check("t5_err_len", 64'(err_len), 64'd1);
    check("t5_err_dst", 64'(err_dst), 64'd0);

    // T3: out-of-range destinations dropped, next packet routed normally.
    x0 = xfers;
    send_pkt(4'd14, 3, 1'b0, 8'h03);
    check("t3_err_dst", 64'(err_dst), 64'd1);
    send_pkt(4'd12, 1, 1'b0, 8'h13);
    check("t3_drop_xfers", 64'(xfers - x0), 64'd0);
    send_pkt(4'd2, 2, 1'b1, 8'h33);
    check("t3_fwd_xfers", 64'(xfers - x0), 64'd2);
    check("t3_err_dst_sticky", 64'(err_dst), 64'd1);

    // T6: reset in the middle of a packet to output 7.
    exp_sel = 7;
    drive_flit({8'h06, 8'h00, 12'h5A5, 4'd7}, 1'b0, 1'b1, acc);
    drive_flit({8'h06, 8'h01, 12'h5A5, 4'd7}, 1'b0, 1'b1, acc);
    in_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    in_valid = 1'b1;
    in_data  = {8'h02, 8'h00, 12'h5A5, 4'd9};
    @(negedge clk);
    check("t6_req", 64'(req), 64'd0);
    check("t6_valid", 64'(valid_o), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd0);
    check("t6_err_len", 64'(err_len), 64'd0);
    check("t6_err_dst", 64'(err_dst), 64'd0);
    exp_err_len = 1'b0;
    @(posedge clk); #1;

    // T2: READY_i toggling every cycle over a 4-flit packet.
    ready_toggle = 1'b1;
    x0 = xfers;
    send_pkt(4'd9, 4, 1'b1, 8'h02);
    ready_toggle = 1'b0;
    check("t2_xfers", 64'(xfers - x0), 64'd4);
    check("t2_err_len", 64'(err_len), 64'd1);
    @(posedge clk); #1;

    // T4: single-flit packet to output 0, then a packet to the top output.
    x0 = xfers;
    send_pkt(4'd0, 1, 1'b1, 8'h04);
    @(negedge clk);
    check("t4_req_drop", 64'(req), 64'd0);
    check("t4_sel0", 64'(sel_o), 64'd0);
    @(posedge clk); #1;
    send_pkt(4'd11, 2, 1'b1, 8'h14);
    check("t4_sel11", 64'(sel_o), 64'd11);
    check("t4_xfers", 64'(xfers - x0), 64'd3);

    repeat (3) @(posedge clk);
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
